// File: rtl/instr_encoder_if.sv
// Mnemonic-record input, instruction-memory write port and session status of the encoder.
interface instr_encoder_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [25:0] in_imm;
  logic        in_last;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        done;
  logic        err_undef;
  logic        full;
  logic [15:0] word_count;

  modport master (
    output start, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    input  in_ready, im_we, im_addr, im_wdata, done, err_undef, full, word_count
  );

  modport slave (
    input  start, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
    output in_ready, im_we, im_addr, im_wdata, done, err_undef, full, word_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic records into MIPS words and writes them to instruction memory from BASE_ADDR.
// One word per two cycles (accept, then write); in_ready drops while a word is being written.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          MAX_WORDS = 4096
) (
  input logic          clk,
  input logic          reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERROR} state_t;

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] cnt_q, cnt_next;
  logic        err_q, full_q, last_q;
  logic        hs, start_ok, hit_max;
  logic        enc_ok;
  logic [31:0] enc_word;
  logic [4:0]  rs, rt, rd, sh;
  logic [15:0] imm16;

  assign rs    = bus.in_rs;
  assign rt    = bus.in_rt;
  assign rd    = bus.in_rd;
  assign sh    = bus.in_shamt;
  assign imm16 = bus.in_imm[15:0];

  function automatic logic [31:0] r_word(input logic [4:0] f_rs, f_rt, f_rd, f_sh,
                                         input logic [5:0] funct);
    return {6'b000000, f_rs, f_rt, f_rd, f_sh, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] f_rs, f_rt,
                                         input logic [15:0] f_imm);
    return {opc, f_rs, f_rt, f_imm};
  endfunction

  // Field forcing is done here so callers may leave unused fields as garbage.
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    case (bus.in_op)
      6'd0:  enc_word = r_word(rs, rt, rd, 5'd0, 6'h20);
      6'd1:  enc_word = r_word(rs, rt, rd, 5'd0, 6'h21);
      6'd2:  enc_word = r_word(rs, rt, rd, 5'd0, 6'h22);
      6'd3:  enc_word = r_word(rs, rt, rd, 5'd0, 6'h23);
      6'd4:  enc_word = r_word(5'd0, rt, rd, sh, 6'h00);
      6'd5:  enc_word = r_word(5'd0, rt, rd, sh, 6'h02);
      6'd6:  enc_word = r_word(5'd0, rt, rd, sh, 6'h03);
      6'd7:  enc_word = r_word(rs, rt, rd, sh, 6'h04);
      6'd8:  enc_word = r_word(rs, rt, rd, sh, 6'h06);
      6'd9:  enc_word = r_word(rs, rt, rd, sh, 6'h07);
      6'd10: enc_word = r_word(rs, rt, rd, 5'd0, 6'h2A);
      6'd11: enc_word = r_word(rs, rt, rd, 5'd0, 6'h2B);
      6'd12: enc_word = r_word(rs, rt, rd, 5'd0, 6'h24);
      6'd13: enc_word = r_word(rs, rt, rd, 5'd0, 6'h25);
      6'd14: enc_word = r_word(rs, rt, rd, 5'd0, 6'h26);
      6'd15: enc_word = r_word(rs, rt, rd, 5'd0, 6'h27);
      6'd16: enc_word = i_word(6'h08, rs, rt, imm16);
      6'd17: enc_word = i_word(6'h09, rs, rt, imm16);
      6'd18: enc_word = i_word(6'h0C, rs, rt, imm16);
      6'd19: enc_word = i_word(6'h0D, rs, rt, imm16);
      6'd20: enc_word = i_word(6'h0E, rs, rt, imm16);
      6'd21: enc_word = i_word(6'h0F, 5'd0, rt, imm16);
      6'd22: enc_word = i_word(6'h0A, rs, rt, imm16);
      6'd23: enc_word = i_word(6'h0B, rs, rt, imm16);
      6'd24: enc_word = i_word(6'h20, rs, rt, imm16);
      6'd25: enc_word = i_word(6'h24, rs, rt, imm16);
      6'd26: enc_word = i_word(6'h21, rs, rt, imm16);
      6'd27: enc_word = i_word(6'h25, rs, rt, imm16);
      6'd28: enc_word = i_word(6'h23, rs, rt, imm16);
      6'd29: enc_word = i_word(6'h28, rs, rt, imm16);
      6'd30: enc_word = i_word(6'h29, rs, rt, imm16);
      6'd31: enc_word = i_word(6'h2B, rs, rt, imm16);
      6'd32: enc_word = i_word(6'h04, rs, rt, imm16);
      6'd33: enc_word = i_word(6'h05, rs, rt, imm16);
      6'd34: enc_word = i_word(6'h06, rs, 5'd0, imm16);
      6'd35: enc_word = i_word(6'h01, rs, 5'd0, imm16);
      6'd36: enc_word = i_word(6'h01, rs, 5'd1, imm16);
      6'd37: enc_word = i_word(6'h07, rs, 5'd0, imm16);
      6'd38: enc_word = {6'h02, bus.in_imm};
      6'd39: enc_word = {6'h03, bus.in_imm};
      6'd40: enc_word = {6'b000000, rs, 15'd0, 6'h08};
      6'd41: enc_word = {6'b000000, rs, 5'd0, rd, 5'd0, 6'h09};
      6'd42: enc_word = {6'b010000, 5'b00000, rt, rd, 11'd0};
      6'd43: enc_word = {6'b010000, 5'b00100, rt, rd, 11'd0};
      6'd44: enc_word = 32'h4200_0018;
      default: enc_ok = 1'b0;
    endcase
  end

  assign hs       = bus.in_valid && (state_q == ACCEPT);
  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign cnt_next = cnt_q + 16'd1;
  assign hit_max  = (cnt_next == MAX_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_ok) state_d = ACCEPT;
      ACCEPT:            if (hs) state_d = enc_ok ? WRITE : ERROR;
      WRITE:             state_d = (last_q || hit_max) ? DONE : ACCEPT;
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
        err_q  <= 1'b0;
        full_q <= 1'b0;
      end
      if (hs) begin
        if (enc_ok) begin
          wdata_q <= enc_word;
          last_q  <= bus.in_last;
        end else begin
          err_q <= 1'b1;
        end
      end
      // full only flags a session cut short by the word limit, not one that ended on last.
      if (state_q == WRITE) begin
        addr_q <= addr_q + 32'd4;
        cnt_q  <= cnt_next;
        if (hit_max && !last_q) full_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state_q == ACCEPT);
  assign bus.im_we      = (state_q == WRITE);
  assign bus.done       = (state_q == DONE);
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.err_undef  = err_q;
  assign bus.full       = full_q;
  assign bus.word_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: session-level model plus literal pins on key encodings.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, sel, start, in_valid, last;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sh;
  logic [25:0] imm;

  always #5 clk = ~clk;

  instr_encoder_if ifa();
  instr_encoder_if ifb();

  assign ifa.start    = start & ~sel;
  assign ifb.start    = start & sel;
  assign ifa.in_valid = in_valid & ~sel;
  assign ifb.in_valid = in_valid & sel;
  assign ifa.in_op = op;  assign ifb.in_op = op;
  assign ifa.in_rs = rs;  assign ifb.in_rs = rs;
  assign ifa.in_rt = rt;  assign ifb.in_rt = rt;
  assign ifa.in_rd = rd;  assign ifb.in_rd = rd;
  assign ifa.in_shamt = sh;  assign ifb.in_shamt = sh;
  assign ifa.in_imm = imm;   assign ifb.in_imm = imm;
  assign ifa.in_last = last; assign ifb.in_last = last;

  instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(4096)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  instr_encoder #(.BASE_ADDR(BASE), .MAX_WORDS(2))    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic        m_we, m_rdy, m_done, m_err, m_full;
  logic [31:0] m_addr, m_wdata;
  logic [15:0] m_cnt;
  assign m_we    = sel ? ifb.im_we      : ifa.im_we;
  assign m_rdy   = sel ? ifb.in_ready   : ifa.in_ready;
  assign m_done  = sel ? ifb.done       : ifa.done;
  assign m_err   = sel ? ifb.err_undef  : ifa.err_undef;
  assign m_full  = sel ? ifb.full       : ifa.full;
  assign m_addr  = sel ? ifb.im_addr    : ifa.im_addr;
  assign m_wdata = sel ? ifb.im_wdata   : ifa.im_wdata;
  assign m_cnt   = sel ? ifb.word_count : ifa.word_count;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Encoding tables: kind 0 undef, 1 R, 2 I, 3 J, 4 jr, 5 jalr, 6 cop0, 7 eret.
  int kind_t[64];
  int code_t[64];
  int rsf[64];
  int rtf[64];
  bit shz[64];

  function automatic logic [31:0] model_word(input logic [5:0] o, input logic [4:0] s, t, d, h,
                                             input logic [25:0] im);
    logic [4:0] s2, t2, h2;
    logic [5:0] c;
    c  = 6'(code_t[o]);
    s2 = (rsf[o] >= 0) ? 5'(rsf[o]) : s;
    t2 = (rtf[o] >= 0) ? 5'(rtf[o]) : t;
    h2 = shz[o] ? 5'd0 : h;
    case (kind_t[o])
      1: return {6'd0, s2, t2, d, h2, c};
      2: return {c, s2, t2, im[15:0]};
      3: return {c, im};
      4: return {6'd0, s, 15'd0, 6'h08};
      5: return {6'd0, s, 5'd0, d, 5'd0, 6'h09};
      6: return {6'h10, c[4:0], t, d, 11'd0};
      7: return 32'h4200_0018;
      default: return 32'h0;
    endcase
  endfunction

  // Session model of whichever DUT sel points at.
  bit          m_acc, e_done, e_full, e_err;
  logic [31:0] e_addr;
  int          e_cnt, e_max;
  logic [63:0] expq[$];
  logic [31:0] wlog_addr[$], wlog_data[$];

  task automatic model_reset(input int mx);
    m_acc = 0; e_done = 0; e_full = 0; e_err = 0;
    e_addr = BASE; e_cnt = 0; e_max = mx;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(m_cnt), 32'(e_cnt));
    check({tag, "_addr"},  m_addr, e_addr);
    check({tag, "_done"},  32'(m_done), 32'(e_done));
    check({tag, "_full"},  32'(m_full), 32'(e_full));
    check({tag, "_err"},   32'(m_err), 32'(e_err));
    check({tag, "_ready"}, 32'(m_rdy), 32'(m_acc));
  endtask

  // Every write the DUT issues must match the next model-predicted write.
  logic prev_we = 1'b0;
  logic [63:0] exp_w;
  always @(negedge clk) begin
    if (m_we === 1'b1) begin
      check("we_single_cycle", 32'(prev_we), 32'd0);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", m_addr, m_wdata);
      end else begin
        exp_w = expq.pop_front();
        check("write_addr", m_addr, exp_w[63:32]);
        check("write_data", m_wdata, exp_w[31:0]);
      end
      wlog_addr.push_back(m_addr);
      wlog_data.push_back(m_wdata);
    end
    prev_we = m_we;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset(sel ? 2 : 4096);
  endtask

  task automatic start_sess();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (!m_acc) begin
      m_acc = 1; e_addr = BASE; e_cnt = 0; e_done = 0; e_full = 0; e_err = 0;
    end
  endtask

  task automatic send(input logic [5:0] o, input logic [4:0] s, t, d, h,
                      input logic [25:0] im, input logic l);
    bit exp_hs, hs;
    exp_hs = m_acc;
    hs = 0;
    op = o; rs = s; rt = t; rd = d; sh = h; imm = im; last = l;
    in_valid = 1'b1;
    for (int i = 0; i < 12 && !hs; i++) begin
      if (m_rdy === 1'b1) begin
        @(posedge clk);
        hs = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (hs) begin
      if (kind_t[o] != 0) begin
        expq.push_back({e_addr, model_word(o, s, t, d, h, im)});
        e_addr += 32'd4;
        e_cnt++;
        if (l || e_cnt == e_max) begin
          m_acc = 0; e_done = 1; e_full = (e_cnt == e_max) && !l;
        end
      end else begin
        m_acc = 0; e_err = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("handshake", 32'(hs), 32'(exp_hs));
    @(posedge clk);
    @(negedge clk);
    check_status("status");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exceeded, bench stopped");
    $fatal(1, "watchdog");
  end

  initial begin
    int rf[16];
    int ic[22];
    int b;
    rf = '{'h20, 'h21, 'h22, 'h23, 'h00, 'h02, 'h03, 'h04,
           'h06, 'h07, 'h2A, 'h2B, 'h24, 'h25, 'h26, 'h27};
    ic = '{'h08, 'h09, 'h0C, 'h0D, 'h0E, 'h0F, 'h0A, 'h0B, 'h20, 'h24, 'h21,
           'h25, 'h23, 'h28, 'h29, 'h2B, 'h04, 'h05, 'h06, 'h01, 'h01, 'h07};
    for (int i = 0; i < 64; i++) begin
      kind_t[i] = 0; code_t[i] = 0; rsf[i] = -1; rtf[i] = -1; shz[i] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      kind_t[i] = 1; code_t[i] = rf[i]; shz[i] = !(i >= 4 && i <= 9);
    end
    rsf[4] = 0; rsf[5] = 0; rsf[6] = 0;
    for (int i = 0; i < 22; i++) begin
      kind_t[16+i] = 2; code_t[16+i] = ic[i];
    end
    rsf[21] = 0; rtf[34] = 0; rtf[35] = 0; rtf[37] = 0; rtf[36] = 1;
    kind_t[38] = 3; code_t[38] = 2;
    kind_t[39] = 3; code_t[39] = 3;
    kind_t[40] = 4; kind_t[41] = 5;
    kind_t[42] = 6; code_t[42] = 0;
    kind_t[43] = 6; code_t[43] = 4;
    kind_t[44] = 7;

    sel = 1'b0; start = 1'b0; in_valid = 1'b0; last = 1'b0; reset = 1'b1;
    op = '0; rs = '0; rt = '0; rd = '0; sh = '0; imm = '0;
    do_reset();
    check("rst_ready", 32'(m_rdy), 32'd0);
    check("rst_we", 32'(m_we), 32'd0);
    check("rst_addr", m_addr, 32'h3000);
    check("rst_wdata", m_wdata, 32'h0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    check("rst_full", 32'(m_full), 32'd0);
    check("rst_count", 32'(m_cnt), 32'd0);

    // reset held together with start must win
    @(negedge clk) begin reset = 1'b1; start = 1'b1; end
    @(negedge clk) check("rst_over_start", 32'(m_rdy), 32'd0);
    start = 1'b0; reset = 1'b0;

    start_sess();
    check("start_ready", 32'(m_rdy), 32'd1);
    b = wlog_data.size();
    send(6'd19, 5'd0, 5'd1, 5'd0, 5'd0, 26'h1234, 1'b1);
    check("ori_addr", wlog_addr[b], 32'h3000);
    check("ori_data", wlog_data[b], 32'h3401_1234);

    start_sess();
    b = wlog_data.size();
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0, 1'b0);
    send(6'd36, 5'd4, 5'd9, 5'd0, 5'd0, 26'h3, 1'b1);
    check("addu_data", wlog_data[b], 32'h0022_1821);
    check("bgez_addr", wlog_addr[b+1], 32'h3004);
    check("bgez_data", wlog_data[b+1], 32'h0481_0003);
    check("two_count", 32'(m_cnt), 32'd2);

    start_sess();
    b = wlog_data.size();
    send(6'd42, 5'd31, 5'd2, 5'd12, 5'd5, 26'h3FF_FFFF, 1'b0);
    send(6'd44, 5'd31, 5'd31, 5'd31, 5'd31, 26'h2AA_AAAA, 1'b1);
    check("mfc0_data", wlog_data[b], 32'h4002_6000);
    check("eret_data", wlog_data[b+1], 32'h4200_0018);
    check("eret_done", 32'(m_done), 32'd1);
    check("eret_ready", 32'(m_rdy), 32'd0);

    start_sess();
    b = wlog_data.size();
    send(6'd4,  5'd9,  5'd2,  5'd3,  5'd7, 26'h0,       1'b0);
    send(6'd15, 5'd1,  5'd2,  5'd3,  5'd5, 26'h0,       1'b0);
    send(6'd21, 5'd5,  5'd6,  5'd0,  5'd0, 26'h0BEEF,   1'b0);
    send(6'd34, 5'd3,  5'd9,  5'd0,  5'd0, 26'h3FFFC,   1'b0);
    send(6'd35, 5'd3,  5'd9,  5'd0,  5'd0, 26'h8000,    1'b0);
    send(6'd40, 5'd31, 5'd4,  5'd4,  5'd4, 26'h0,       1'b0);
    send(6'd41, 5'd3,  5'd4,  5'd31, 5'd4, 26'h0,       1'b0);
    send(6'd43, 5'd1,  5'd8,  5'd14, 5'd3, 26'h0,       1'b0);
    send(6'd38, 5'd0,  5'd0,  5'd0,  5'd0, 26'h2AB_CDEF, 1'b0);
    send(6'd31, 5'd29, 5'd31, 5'd0,  5'd0, 26'h3FF_FFF0, 1'b1);
    check("sll_data", wlog_data[b], 32'h0002_19C0);
    check("mix_count", 32'(m_cnt), 32'd10);

    start_sess();
    send(6'd50, 5'd1, 5'd2, 5'd3, 5'd4, 26'h1, 1'b0);
    check("undef_err", 32'(m_err), 32'd1);
    check("undef_ready", 32'(m_rdy), 32'd0);
    start_sess();
    check("restart_err", 32'(m_err), 32'd0);
    check("restart_addr", m_addr, 32'h3000);
    check("restart_ready", 32'(m_rdy), 32'd1);

    // word limit on the MAX_WORDS=2 instance
    sel = 1'b1;
    model_reset(2);
    start_sess();
    send(6'd19, 5'd0, 5'd1, 5'd0, 5'd0, 26'h1, 1'b0);
    send(6'd1,  5'd1, 5'd2, 5'd3, 5'd0, 26'h0, 1'b0);
    send(6'd0,  5'd4, 5'd5, 5'd6, 5'd0, 26'h0, 1'b0);
    check("max_full", 32'(m_full), 32'd1);
    check("max_done", 32'(m_done), 32'd1);
    check("max_count", 32'(m_cnt), 32'd2);

    // reset while a jal word is being written
    sel = 1'b0;
    do_reset();
    start_sess();
    b = wlog_data.size();
    check("jal_ready", 32'(m_rdy), 32'd1);
    op = 6'd39; rs = 5'd0; rt = 5'd0; rd = 5'd0; sh = 5'd0; imm = 26'h0C00; last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    expq.push_back({BASE, model_word(6'd39, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0C00)});
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    check("jal_we_in_write", 32'(m_we), 32'd1);
    @(negedge clk);
    check("jal_data", wlog_data[b], 32'h0C00_0C00);
    check("rw_we", 32'(m_we), 32'd0);
    check("rw_ready", 32'(m_rdy), 32'd0);
    check("rw_addr", m_addr, 32'h3000);
    check("rw_wdata", m_wdata, 32'h0);
    check("rw_done", 32'(m_done), 32'd0);
    check("rw_err", 32'(m_err), 32'd0);
    check("rw_full", 32'(m_full), 32'd0);
    check("rw_count", 32'(m_cnt), 32'd0);
    reset = 1'b0;
    model_reset(4096);
    repeat (3) @(negedge clk);

    check("pending_writes", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
